fault_scan_ctrl: RTL and testbench

FAULT_SCAN_CTRL -- requirements
Module: fault_scan_ctrl

---
 rtl/fault_pkg.sv | 26 ++
 rtl/fault_scan_ctrl_golden_cmp.sv | 29 ++
 rtl/fault_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fault_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared definitions for the adder fault-scan controller.
//   scan_state_t : controller FSM states
//   RGB_*        : status LED colour codes, bit 2 = red, 1 = green, 0 = blue
//   vec_width()  : width of the packed {a,b,cin} test vector for a given operand width
package fault_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } scan_state_t;

  localparam logic [2:0] RGB_OFF  = 3'b000;
  localparam logic [2:0] RGB_BUSY = 3'b001;
  localparam logic [2:0] RGB_PASS = 3'b010;
  localparam logic [2:0] RGB_FAIL = 3'b100;
  localparam int         RGB_RED  = 2;

  // {a, b, cin}: two operands plus one carry-in bit
  function automatic int vec_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/fault_scan_ctrl_golden_cmp.sv
// adder_golden_cmp: combinational reference adder and comparator.
//   a, b, cin  : operands currently driven to the circuit under test
//   sum, cout  : result returned by the circuit under test
//   mismatch   : high when the returned result differs from the golden sum
//   diff       : golden {cout,sum} XOR returned {cout,sum}
module adder_golden_cmp
  import fault_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             mismatch,
  output logic [WIDTH:0]   diff
);

  logic [WIDTH:0] golden;

  always_comb begin
    // Widen before adding so the carry-out is kept
    golden   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff     = golden ^ {cout, sum};
    mismatch = |diff;
  end

endmodule

// File: rtl/fault_scan_ctrl.sv
// fault_scan_ctrl: exhaustive test controller for a WIDTH-bit adder.
// Steps every {a,b,cin} vector through the CUT, waits SETTLE cycles, compares
// against a golden sum and accumulates fault statistics.
//   clk, rst (async, active-low)
//   start, mode         : launch a scan (mode 0 single pass, 1 continuous)
//   dut_a/dut_b/dut_cin : registered operands to the CUT
//   dut_sum/dut_cout    : CUT result
//   busy, done          : scanning / end-of-pass pulse
//   fault_flag, fault_cnt, first_fail_vec, first_fail_diff : results
//   RGB                 : status LED
module fault_scan_ctrl
  import fault_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  output logic [WIDTH-1:0]             dut_a,
  output logic [WIDTH-1:0]             dut_b,
  output logic                         dut_cin,
  input  logic [WIDTH-1:0]             dut_sum,
  input  logic                         dut_cout,
  output logic                         busy,
  output logic                         done,
  output logic                         fault_flag,
  output logic [CNT_W-1:0]             fault_cnt,
  output logic [vec_width(WIDTH)-1:0]  first_fail_vec,
  output logic [WIDTH:0]               first_fail_diff,
  output logic [2:0]                   RGB
);

  localparam int             VW        = vec_width(WIDTH);
  localparam logic [VW-1:0]  VEC_MAX   = '1;
  localparam logic [3:0]     WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  scan_state_t      state_reg, state_next;
  logic [VW-1:0]    vec_reg, vec_next;
  logic [VW-1:0]    opnd_reg, opnd_next;
  logic [3:0]       wait_reg, wait_next;
  logic             mode_reg, mode_next;
  logic             flag_reg, flag_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [VW-1:0]    ffv_reg, ffv_next;
  logic [WIDTH:0]   ffd_reg, ffd_next;

  logic             mismatch;
  logic [WIDTH:0]   diff;

  assign {dut_a, dut_b, dut_cin} = opnd_reg;
  assign fault_flag      = flag_reg;
  assign fault_cnt       = cnt_reg;
  assign first_fail_vec  = ffv_reg;
  assign first_fail_diff = ffd_reg;

  adder_golden_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a        (dut_a),
    .b        (dut_b),
    .cin      (dut_cin),
    .sum      (dut_sum),
    .cout     (dut_cout),
    .mismatch (mismatch),
    .diff     (diff)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      vec_reg   <= '0;
      opnd_reg  <= '0;
      wait_reg  <= '0;
      mode_reg  <= 1'b0;
      flag_reg  <= 1'b0;
      cnt_reg   <= '0;
      ffv_reg   <= '0;
      ffd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      opnd_reg  <= opnd_next;
      wait_reg  <= wait_next;
      mode_reg  <= mode_next;
      flag_reg  <= flag_next;
      cnt_reg   <= cnt_next;
      ffv_reg   <= ffv_next;
      ffd_reg   <= ffd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    opnd_next  = opnd_reg;
    wait_next  = wait_reg;
    mode_next  = mode_reg;
    flag_next  = flag_reg;
    cnt_next   = cnt_reg;
    ffv_next   = ffv_reg;
    ffd_next   = ffd_reg;
    busy       = 1'b0;
    done       = 1'b0;
    RGB        = RGB_OFF;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (state_reg == ST_DONE) begin
          RGB = flag_reg ? RGB_FAIL : RGB_PASS;
        end
        if (start) begin
          state_next = ST_APPLY;
          vec_next   = '0;
          mode_next  = mode;
          flag_next  = 1'b0;
          cnt_next   = '0;
          ffv_next   = '0;
          ffd_next   = '0;
        end
      end

      ST_APPLY: begin
        busy       = 1'b1;
        RGB        = RGB_BUSY;
        opnd_next  = vec_reg;
        wait_next  = '0;
        state_next = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
      end

      ST_WAIT: begin
        busy = 1'b1;
        RGB  = RGB_BUSY;
        if (wait_reg == WAIT_LAST) begin
          state_next = ST_CHECK;
        end else begin
          wait_next = wait_reg + 4'd1;
        end
      end

      ST_CHECK: begin
        busy = 1'b1;
        RGB  = RGB_BUSY;
        if (mismatch) begin
          flag_next = 1'b1;
          if (cnt_reg != '1) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
          // flag_reg still low means this is the first mismatch since start
          if (!flag_reg) begin
            ffv_next = opnd_reg;
            ffd_next = diff;
          end
        end
        if (vec_reg == VEC_MAX) begin
          done = 1'b1;
          if (mode_reg) begin
            vec_next   = '0;
            state_next = ST_APPLY;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          vec_next   = vec_reg + VW'(1);
          state_next = ST_APPLY;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Continuous scans show accumulated faults in red on top of the busy colour
    if (mode_reg && flag_reg) begin
      RGB[RGB_RED] = 1'b1;
    end
  end

endmodule

// File: tb/tb_fault_scan_ctrl.sv
// Testbench for fault_scan_ctrl: three instances (WIDTH 1/2/4) each driven by a
// behavioural adder with a programmable fault, checked by tables, hand sequences
// and a randomized fault sweep against an exhaustive reference model.
module tb_fault_scan_ctrl;

  typedef struct packed {
    logic        all;   // fault applies to every vector
    logic [16:0] vec;   // otherwise only to this {a,b,cin}
    logic [8:0]  clr;   // stuck-at-0 bits of {cout,sum}
    logic [8:0]  set;   // stuck-at-1 bits
    logic [8:0]  xr;    // inverted bits
  } fault_t;

  typedef struct {
    fault_t f;
    int     cnt;
    int     fvec;
    int     fdiff;
    int     rgb;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [2:0] start_v;
  fault_t     flt;
  int         checks = 0;
  int         failures = 0;
  int         sel = 0;
  row_t       tbl[6];

  always #5 clk = ~clk;

  function automatic int cut_f(input int w, input int a, input int b, input int ci, input fault_t f);
    int v, r;
    v = (a << (w + 1)) | (b << 1) | ci;
    r = a + b + ci;
    if (f.all || v == int'(f.vec)) r = ((r & ~int'(f.clr)) | int'(f.set)) ^ int'(f.xr);
    return r & ((1 << (w + 1)) - 1);
  endfunction

  function automatic fault_t mkf(input int all, input int vec, input int clr, input int set, input int xr);
    fault_t f;
    f.all = 1'(all);
    f.vec = 17'(vec);
    f.clr = 9'(clr);
    f.set = 9'(set);
    f.xr  = 9'(xr);
    return f;
  endfunction

  // Exhaustive expectation for one pass: walk every vector, compare CUT to a+b+cin
  function automatic void model(input int w, input int cmax, input fault_t f,
                                output int cnt, output int fvec, output int fdiff);
    int a, b, ci, g, c;
    bit found;
    cnt = 0; fvec = 0; fdiff = 0; found = 0;
    for (int v = 0; v < (1 << (2 * w + 1)); v++) begin
      a  = v >> (w + 1);
      b  = (v >> 1) & ((1 << w) - 1);
      ci = v & 1;
      g  = a + b + ci;
      c  = cut_f(w, a, b, ci, f);
      if (g != c) begin
        if (!found) begin
          found = 1; fvec = v; fdiff = g ^ c;
        end
        if (cnt < cmax) cnt++;
      end
    end
  endfunction

  // WIDTH=1, SETTLE=0
  logic [0:0] a1, b1, s1; logic cin1, co1, busy1, done1, flag1;
  logic [7:0] cnt1; logic [2:0] fv1; logic [1:0] fd1; logic [2:0] rgb1;
  assign {co1, s1} = 2'(cut_f(1, int'(a1), int'(b1), int'(cin1), flt));
  fault_scan_ctrl #(.WIDTH(1), .CNT_W(8), .SETTLE(0)) u_w1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(s1), .dut_cout(co1),
    .busy(busy1), .done(done1), .fault_flag(flag1), .fault_cnt(cnt1),
    .first_fail_vec(fv1), .first_fail_diff(fd1), .RGB(rgb1));

  // WIDTH=2, CNT_W=3, SETTLE=3
  logic [1:0] a2, b2, s2; logic cin2, co2, busy2, done2, flag2;
  logic [2:0] cnt2; logic [4:0] fv2; logic [2:0] fd2; logic [2:0] rgb2;
  assign {co2, s2} = 3'(cut_f(2, int'(a2), int'(b2), int'(cin2), flt));
  fault_scan_ctrl #(.WIDTH(2), .CNT_W(3), .SETTLE(3)) u_w2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode),
    .dut_a(a2), .dut_b(b2), .dut_cin(cin2), .dut_sum(s2), .dut_cout(co2),
    .busy(busy2), .done(done2), .fault_flag(flag2), .fault_cnt(cnt2),
    .first_fail_vec(fv2), .first_fail_diff(fd2), .RGB(rgb2));

  // WIDTH=4, CNT_W=4, SETTLE=1
  logic [3:0] a4, b4, s4; logic cin4, co4, busy4, done4, flag4;
  logic [3:0] cnt4; logic [8:0] fv4; logic [4:0] fd4; logic [2:0] rgb4;
  assign {co4, s4} = 5'(cut_f(4, int'(a4), int'(b4), int'(cin4), flt));
  fault_scan_ctrl #(.WIDTH(4), .CNT_W(4), .SETTLE(1)) u_w4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode),
    .dut_a(a4), .dut_b(b4), .dut_cin(cin4), .dut_sum(s4), .dut_cout(co4),
    .busy(busy4), .done(done4), .fault_flag(flag4), .fault_cnt(cnt4),
    .first_fail_vec(fv4), .first_fail_diff(fd4), .RGB(rgb4));

  logic obs_done, obs_busy, obs_flag;
  int   obs_cnt, obs_fvec, obs_fdiff, obs_rgb, obs_opv;

  always_comb begin
    obs_done = done1; obs_busy = busy1; obs_flag = flag1;
    obs_cnt = int'(cnt1); obs_fvec = int'(fv1); obs_fdiff = int'(fd1);
    obs_rgb = int'(rgb1); obs_opv = int'({a1, b1, cin1});
    if (sel == 1) begin
      obs_done = done2; obs_busy = busy2; obs_flag = flag2;
      obs_cnt = int'(cnt2); obs_fvec = int'(fv2); obs_fdiff = int'(fd2);
      obs_rgb = int'(rgb2); obs_opv = int'({a2, b2, cin2});
    end else if (sel == 2) begin
      obs_done = done4; obs_busy = busy4; obs_flag = flag4;
      obs_cnt = int'(cnt4); obs_fvec = int'(fv4); obs_fdiff = int'(fd4);
      obs_rgb = int'(rgb4); obs_opv = int'({a4, b4, cin4});
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, obs_done, 0);
    chk({tag, "_busy"}, obs_busy, 0);
    chk({tag, "_flag"}, obs_flag, 0);
    chk({tag, "_cnt"}, obs_cnt, 0);
    chk({tag, "_fvec"}, obs_fvec, 0);
    chk({tag, "_fdiff"}, obs_fdiff, 0);
    chk({tag, "_rgb"}, obs_rgb, 0);
    chk({tag, "_opnd"}, obs_opv, 0);
  endtask

  task automatic chk_done_state(input string tag, input int cnt, input int fvec, input int fdiff, input int rgb);
    chk({tag, "_busy"}, obs_busy, 0);
    chk({tag, "_donepulse"}, obs_done, 0);
    chk({tag, "_cnt"}, obs_cnt, cnt);
    chk({tag, "_flag"}, obs_flag, (cnt != 0) ? 1 : 0);
    chk({tag, "_fvec"}, obs_fvec, fvec);
    chk({tag, "_fdiff"}, obs_fdiff, fdiff);
    chk({tag, "_rgb"}, obs_rgb, rgb);
  endtask

  // Pulse start and return the cycle (1 = first cycle after start is taken) done is seen
  task automatic run_pass(input int s, input bit md, input int budget, output int done_cyc);
    @(negedge clk); start_v[s] = 1'b1; mode = md;
    @(negedge clk); start_v[s] = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      if (obs_done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (obs_done) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int dc, n, ec, ev, ed, seen;
    bit found;
    rst = 1'b0; mode = 1'b0; start_v = '0; flt = mkf(0, 0, 0, 0, 0);

    //             all vec clr  set  xr      cnt fvec fdiff rgb
    tbl[0] = '{mkf(1, 0, 0,   0,   0),   0,  0,   0,   3'b010};
    tbl[1] = '{mkf(1, 0, 0,   2,   0),   4,  0,   2,   3'b100};
    tbl[2] = '{mkf(1, 0, 2,   0,   0),   4,  3,   2,   3'b100};
    tbl[3] = '{mkf(1, 0, 0,   1,   0),   4,  0,   1,   3'b100};
    tbl[4] = '{mkf(1, 0, 1,   0,   0),   4,  1,   1,   3'b100};
    tbl[5] = '{mkf(0, 5, 0,   0,   3),   1,  5,   3,   3'b100};

    // Reset state of every instance, then idle after release
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk_zero("reset");
    end
    @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("idle_busy", obs_busy, 0);
      chk("idle_rgb", obs_rgb, 0);
    end

    // Table of fixed faults on the WIDTH=1 instance, single mode
    sel = 0;
    for (int r = 0; r < 6; r++) begin
      flt = tbl[r].f;
      run_pass(0, 1'b0, 40, dc);
      chk("row_done_cycle", dc, 16);
      @(negedge clk);
      chk_done_state("row", tbl[r].cnt, tbl[r].fvec, tbl[r].fdiff, tbl[r].rgb);
      repeat (3) @(negedge clk);
      chk("row_hold_cnt", obs_cnt, tbl[r].cnt);
      $display("row %0d done_cycle=%0d cnt=%0d fvec=%0d fdiff=%0d rgb=%0d", r, dc, obs_cnt, obs_fvec, obs_fdiff, obs_rgb);
    end

    // WIDTH=4, CNT_W=4, sum[0] stuck-at-0: 256 mismatches saturate at 15
    sel = 2;
    flt = mkf(1, 0, 1, 0, 0);
    run_pass(2, 1'b0, 2000, dc);
    chk("w4_done_cycle", dc, 512 * 3);
    @(negedge clk);
    chk_done_state("w4", 15, 1, 1, 3'b100);
    $display("w4 done_cycle=%0d cnt=%0d fvec=%0d", dc, obs_cnt, obs_fvec);

    // Continuous, fault-free: done every 16 cycles; start while busy ignored
    sel = 0;
    flt = mkf(0, 0, 0, 0, 0);
    run_pass(0, 1'b1, 40, dc);
    chk("cont_first_done", dc, 16);
    chk("cont_busy_at_done", obs_busy, 1);
    chk("cont_rgb_busy", obs_rgb, 3'b001);
    @(negedge clk); start_v[0] = 1'b1; mode = 1'b0;
    @(negedge clk); start_v[0] = 1'b0;
    chk("cont_busy_after_start", obs_busy, 1);
    wait_done(40, n);
    chk("cont_interval_a", n, 14);
    wait_done(40, n);
    chk("cont_interval_b", n, 16);
    chk("cont_cnt", obs_cnt, 0);
    $display("continuous clean intervals ok_count=%0d", checks);

    // Reset while vector 3 is under test
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (obs_opv == 3) begin
        found = 1;
        break;
      end
    end
    chk("midreset_found_vec3", found, 1);
    #2 rst = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk); rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (obs_done || obs_busy) seen++;
    end
    chk("midreset_stays_idle", seen, 0);

    // Clean single pass after the aborted one
    run_pass(0, 1'b0, 40, dc);
    chk("after_reset_done_cycle", dc, 16);
    @(negedge clk);
    chk_done_state("after_reset", 0, 0, 0, 3'b010);
    $display("after reset pass done_cycle=%0d cnt=%0d", dc, obs_cnt);

    // Continuous with cout stuck-at-1: results accumulate across passes
    flt = mkf(1, 0, 0, 2, 0);
    run_pass(0, 1'b1, 40, dc);
    chk("cont_fault_done1", dc, 16);
    chk("cont_fault_cnt1", obs_cnt, 4);
    chk("cont_fault_rgb", obs_rgb, 3'b101);
    wait_done(40, n);
    chk("cont_fault_interval", n, 16);
    chk("cont_fault_cnt2", obs_cnt, 8);
    chk("cont_fault_fvec", obs_fvec, 0);
    chk("cont_fault_fdiff", obs_fdiff, 2);
    $display("continuous faulty passes cnt=%0d rgb=%0d", obs_cnt, obs_rgb);
    #2 rst = 1'b0;
    #1 chk_zero("cont_stop_reset");
    @(negedge clk); rst = 1'b1;

    // Randomized faults on the WIDTH=2 instance against the exhaustive model
    sel = 1;
    for (int it = 0; it < 8; it++) begin
      flt = mkf($urandom_range(0, 1), $urandom_range(0, 31),
                $urandom_range(0, 1) ? $urandom_range(0, 7) : 0,
                $urandom_range(0, 1) ? $urandom_range(0, 7) : 0,
                $urandom_range(0, 1) ? $urandom_range(0, 7) : 0);
      model(2, 7, flt, ec, ev, ed);
      run_pass(1, 1'b0, 300, dc);
      chk("rnd_done_cycle", dc, 32 * 5);
      @(negedge clk);
      chk_done_state("rnd", ec, ev, ed, (ec != 0) ? 3'b100 : 3'b010);
      $display("rnd %0d all=%0d vec=%0d clr=%0d set=%0d xr=%0d cnt=%0d exp_cnt=%0d",
               it, flt.all, flt.vec, flt.clr, flt.set, flt.xr, obs_cnt, ec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
